// File: rtl/psg_mix_pkg.sv
// Shared types and sample-mixing helpers for the PSG stereo mixer.
// Signed output formatting (PSG_MIX_SIGNED_EN) is selected in psg_stereo_mixer.
package psg_mix_pkg;

    localparam int SAMPLE_W = 10;
    localparam int OUT_W    = 16;

    typedef enum logic [1:0] {
        MONO = 2'b00,
        ABC  = 2'b01,
        ACB  = 2'b10
    } stereo_mode_e;

    typedef enum logic {
        PLAY  = 1'b0,
        MUTED = 1'b1
    } mute_state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } sample_pair_t;

    // Encoding 2'b11 is a second spelling of mono.
    function automatic stereo_mode_e decode_mode(input logic [1:0] mode_bits);
        stereo_mode_e mode;
        case (mode_bits)
            2'b01:   mode = ABC;
            2'b10:   mode = ACB;
            default: mode = MONO;
        endcase
        return mode;
    endfunction

    function automatic sample_pair_t mix_pair(input stereo_mode_e mode,
                                              input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c);
        sample_pair_t        pair;
        logic [SAMPLE_W-1:0] a1, b1, c1, a2, b2, c2;
        a1 = {2'b00, a};
        b1 = {2'b00, b};
        c1 = {2'b00, c};
        a2 = {1'b0, a, 1'b0};
        b2 = {1'b0, b, 1'b0};
        c2 = {1'b0, c, 1'b0};
        case (mode)
            ABC: begin
                pair.l = a2 + b1;
                pair.r = c2 + b1;
            end
            ACB: begin
                pair.l = a2 + c1;
                pair.r = b2 + c1;
            end
            default: begin
                pair.l = a1 + b1 + c1;
                pair.r = a1 + b1 + c1;
            end
        endcase
        return pair;
    endfunction

endpackage

// File: rtl/psg_mix_accum.sv
// One window accumulator/averager; avg is the mean including the current sample,
// valid to register on the CE that completes the window.
module psg_mix_accum
    import psg_mix_pkg::*;
#(
    parameter int DECIM_LOG2 = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                last,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0] avg
);

    localparam int ACC_W = SAMPLE_W + DECIM_LOG2;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    always_comb begin
        sum   = acc_q + ACC_W'(sample);
        acc_d = acc_q;
        if (ce) begin
            acc_d = last ? '0 : sum;
        end
    end

    assign avg = sum[ACC_W-1:DECIM_LOG2];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/psg_stereo_mixer.sv
// Stereo mixer/decimator for the TurboSound PSG pair with idle auto-mute.
// Define PSG_MIX_SIGNED_EN for two's-complement outputs instead of unsigned.
module psg_stereo_mixer
    import psg_mix_pkg::*;
#(
    parameter int DECIM_LOG2   = 3,
    parameter int MUTE_WINDOWS = 256
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic [7:0]       CHANNEL_A,
    input  logic [7:0]       CHANNEL_B,
    input  logic [7:0]       CHANNEL_C,
    input  logic             ACTIVE,
    input  logic [1:0]       STEREO_MODE,
    output logic [OUT_W-1:0] OUT_L,
    output logic [OUT_W-1:0] OUT_R,
    output logic             OUT_VALID
);

    localparam logic [15:0] IDLE_LIMIT = 16'(MUTE_WINDOWS);

    logic win_first;
    logic win_last;

    generate
        if (DECIM_LOG2 == 0) begin : g_no_cnt
            assign win_first = 1'b1;
            assign win_last  = 1'b1;
        end else begin : g_cnt
            logic [DECIM_LOG2-1:0] win_cnt_q;
            logic [DECIM_LOG2-1:0] win_cnt_d;

            always_comb begin
                win_cnt_d = win_cnt_q;
                if (CE) begin
                    win_cnt_d = win_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    win_cnt_q <= '0;
                end else begin
                    win_cnt_q <= win_cnt_d;
                end
            end

            assign win_first = (win_cnt_q == '0);
            assign win_last  = &win_cnt_q;
        end
    endgenerate

    logic [1:0]          mode_q, mode_d;
    logic                act_seen_q, act_seen_d;
    mute_state_e         state_q, state_d;
    logic [15:0]         idle_q, idle_d;
    logic [OUT_W-1:0]    out_l_q, out_l_d;
    logic [OUT_W-1:0]    out_r_q, out_r_d;
    logic                out_valid_q, out_valid_d;
    logic [1:0]          eff_mode;
    logic                window_active;
    sample_pair_t        pair;
    logic [SAMPLE_W-1:0] avg_l, avg_r;
    logic [OUT_W-1:0]    fmt_l, fmt_r;

    // The mode seen on a window's first CE governs every sample of that window.
    assign eff_mode      = win_first ? STEREO_MODE : mode_q;
    assign pair          = mix_pair(decode_mode(eff_mode), CHANNEL_A, CHANNEL_B, CHANNEL_C);
    assign window_active = act_seen_q | ACTIVE;

    psg_mix_accum #(.DECIM_LOG2(DECIM_LOG2)) u_accum_l (
        .clk    (CLK),
        .reset  (RESET),
        .ce     (CE),
        .last   (win_last),
        .sample (pair.l),
        .avg    (avg_l)
    );

    psg_mix_accum #(.DECIM_LOG2(DECIM_LOG2)) u_accum_r (
        .clk    (CLK),
        .reset  (RESET),
        .ce     (CE),
        .last   (win_last),
        .sample (pair.r),
        .avg    (avg_r)
    );

`ifdef PSG_MIX_SIGNED_EN
    assign fmt_l = {~avg_l[SAMPLE_W-1], avg_l[SAMPLE_W-2:0], 6'b0};
    assign fmt_r = {~avg_r[SAMPLE_W-1], avg_r[SAMPLE_W-2:0], 6'b0};
`else
    assign fmt_l = {avg_l, 6'b0};
    assign fmt_r = {avg_r, 6'b0};
`endif

    always_comb begin
        mode_d      = mode_q;
        act_seen_d  = act_seen_q;
        state_d     = state_q;
        idle_d      = idle_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;

        if (CE) begin
            if (win_first) begin
                mode_d = STEREO_MODE;
            end
            act_seen_d = win_last ? 1'b0 : window_active;

            if (state_q == MUTED && ACTIVE) begin
                state_d = PLAY;
                idle_d  = '0;
            end

            // Mute is judged on the next state so an unmute on the completing CE is heard.
            if (win_last) begin
                if (window_active) begin
                    idle_d = '0;
                end else if (idle_q != IDLE_LIMIT) begin
                    idle_d = idle_q + 1'b1;
                end
                if (idle_d == IDLE_LIMIT) begin
                    state_d = MUTED;
                end
                out_valid_d = 1'b1;
                out_l_d     = (state_d == MUTED) ? '0 : fmt_l;
                out_r_d     = (state_d == MUTED) ? '0 : fmt_r;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_q      <= 2'b00;
            act_seen_q  <= 1'b0;
            state_q     <= PLAY;
            idle_q      <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            act_seen_q  <= act_seen_d;
            state_q     <= state_d;
            idle_q      <= idle_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_L     = out_l_q;
    assign OUT_R     = out_r_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: doc/psg_stereo_mixer.md
PSG_STEREO_MIXER -- requirements
Module: psg_stereo_mixer

Interface
- REQ-001 SHALL have parameter DECIM_LOG2, default 3: the window averages 2^DECIM_LOG2 CE samples; legal range 0..6.
- REQ-002 SHALL have parameter MUTE_WINDOWS, default 256: the number of consecutive inactive windows before mute; legal range 1..65535.
- REQ-003 SHALL have port CLK, input, 1 bit: the single global clock; all logic runs on its rising edge.
- REQ-004 SHALL have port RESET, input, 1 bit: reset is synchronous and active-high.
- REQ-005 SHALL have port CE, input, 1 bit: the PSG sample strobe, one CLK wide, the same enable that drives the PSG pair.
- REQ-006 SHALL have ports CHANNEL_A, CHANNEL_B and CHANNEL_C, input, 8 bits each: unsigned channel levels from the TurboSound stage.
- REQ-007 SHALL have port ACTIVE, input, 1 bit: the PSG activity flag.
- REQ-008 SHALL have port STEREO_MODE, input, 2 bits: 00 mono, 01 ABC, 10 ACB, 11 mono.
- REQ-009 SHALL have ports OUT_L and OUT_R, output, 16 bits each: the mixed samples.
- REQ-010 SHALL have port OUT_VALID, output, 1 bit: a one-CLK pulse marking new OUT_L/OUT_R.

Function
- REQ-011 SHALL compute a per-CE sample pair, 10-bit unsigned, maximum 765:
  - ABC: L=2A+B, R=2C+B.
  - ACB: L=2A+C, R=2B+C.
  - mono: L=R=A+B+C.
- REQ-012 SHALL latch STEREO_MODE at the first CE of each window; a change mid-window takes effect at the next window.
- REQ-013 SHALL add L and R into accumulators (10+DECIM_LOG2 bits, no overflow) on every CE, and count CE with a DECIM_LOG2-bit window counter that wraps.
- REQ-014 on the CE that completes a window, SHALL register avg = acc >> DECIM_LOG2 and clear the accumulators; that CE's sample is included in the window.
- REQ-015 SHALL assert OUT_VALID exactly one CLK after the completing CE, high for one CLK; OUT_L/OUT_R update on the same edge and then hold.
- REQ-016 SHALL set the unsigned output to {avg[9:0], 6'b0}; the maximum is 0xBF40.
- REQ-017 SHALL take no action on CLK cycles without CE; inputs are sampled only when CE=1.
- REQ-018 mute FSM, states PLAY and MUTED, evaluated once per completed window:
  - An inactive window is one in which ACTIVE was never 1 on any CE.
  - PLAY moves to MUTED after MUTE_WINDOWS consecutive inactive windows; a 16-bit idle counter saturates at the limit.
  - MUTED returns to PLAY on the first CE where ACTIVE=1; the idle counter clears.
- REQ-019 in MUTED, SHALL drive OUT_L=OUT_R=0x0000 and keep pulsing OUT_VALID every window.
- REQ-020 if the MUTED-to-PLAY transition and a window completion fall on the same CE, SHALL emit that window unmuted.
- REQ-021 with DECIM_LOG2=0, SHALL make every CE a complete window; the window counter is absent.

Reset
- REQ-022 RESET=1 at a CLK edge SHALL set accumulators, window counter and idle counter to 0, the FSM to PLAY, OUT_L=OUT_R=0x0000 and OUT_VALID=0.
- REQ-023 RESET SHALL take priority over CE on the same edge; a window partially accumulated at reset is discarded, never emitted.
- REQ-024 the first window after reset release SHALL start at the first CE.

Configuration
- REQ-025 SHALL support macro PSG_MIX_SIGNED_EN:
  - Defined: outputs are two's complement, out = {~u[15], u[14:0]}, where u is the REQ-016 value.
  - Not defined: outputs are the unsigned value u.
  - Mute drives 0x0000 in both builds.

Structure
- REQ-026 SHALL place the following in package psg_mix_pkg: the stereo-mode enum (MONO, ABC, ACB), the FSM state enum, SAMPLE_W=10 and OUT_W=16.
- REQ-027 SHALL use one sub-module, psg_mix_accum (one accumulator/averager, parameterised by DECIM_LOG2), instantiated once for L and once for R.

Verification
- REQ-028 ABC, A=255, B=C=0, ACTIVE=1, 8 CEs -> one OUT_VALID pulse, OUT_L=0x7F80, OUT_R=0x0000, pulse one CLK after the 8th CE.
- REQ-029 mono, A=B=C=100, 8 CEs -> OUT_L=OUT_R=0x4B00; in a PSG_MIX_SIGNED_EN build -> 0xCB00.
- REQ-030 ACB, A=0, B=255, C=0, STEREO_MODE changed to ABC at CE 4 -> window 1 gives OUT_L=0x0000, OUT_R=0x7F80; window 2 gives OUT_L=OUT_R=0x3FC0.
- REQ-031 ACTIVE=0 for 256 windows with A=200 -> the 256th output and later are 0x0000; ACTIVE=1 on the next CE -> that window outputs nonzero.
- REQ-032 RESET pulsed after 5 CEs of A=255 -> no OUT_VALID; the next valid pulse comes after 8 fresh CEs, and its value reflects only post-reset samples.
- REQ-033 random CE gaps of 0..20 idle CLKs between strobes -> outputs match the software model bit-exactly over 10,000 windows.
